// File: rtl/cdc_sched_pkg.sv
// cdc_sched_pkg: shared types and constants for the fast-to-slow slot scheduler.
// Holds the FSM state encoding and the idle-slot counter width.
package cdc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    LOAD = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int IDLE_CNT_W = 16;

  function automatic logic [IDLE_CNT_W-1:0] sat_inc(
    input logic [IDLE_CNT_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cdc_slot_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from
// last_grant+1 (mod NREQ); reports one-hot grant, its index and any.
module rr_arbiter
  import cdc_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any
);

  int            idx;
  logic [IW-1:0] k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    k         = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_grant) + i) % NREQ;
      k   = IW'(idx);
      if (!any && req[k]) begin
        any       = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = k;
      end
    end
  end

endmodule

// File: rtl/cdc_slot_scheduler.sv
// cdc_slot_scheduler: one fast-to-slow hold register shared round-robin,
// reloaded just after a slow falling edge. Option: CDC_SCHED_IDLE_CNT_EN.
module cdc_slot_scheduler
  import cdc_sched_pkg::*;
#(
  parameter  int W           = 12,
  parameter  int NREQ        = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int IW          = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              slow_clk,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      xfer_data,
  output logic [IW-1:0]     xfer_id,
`ifdef CDC_SCHED_IDLE_CNT_EN
  output logic              xfer_strobe,
  output logic [IDLE_CNT_W-1:0] idle_cnt
`else
  output logic              xfer_strobe
`endif
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic                   s_prev;
  logic                   fall;
  logic                   rise;

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign fall   = s_prev & ~s_sync;
  assign rise   = ~s_prev & s_sync;

  // Chain clears to 0 so reset never fabricates a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
      s_prev <= s_sync;
    end
  end

  logic [W-1:0] words [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words[g] = req_data[g*W +: W];
  end

  logic [IW-1:0]   last_grant;
  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req       (req_valid),
    .last_grant(last_grant),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  state_t          state;
  state_t          state_nx;
  logic [IW-1:0]   win_q;
  logic [NREQ-1:0] win_oh_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (fall) state_nx = ARB;
      ARB:  state_nx = arb_any ? LOAD : HOLD;
      LOAD: state_nx = HOLD;
      HOLD: if (rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == LOAD) req_ready = win_oh_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      win_q       <= '0;
      win_oh_q    <= '0;
      last_grant  <= IW'(NREQ - 1);
      xfer_data   <= '0;
      xfer_id     <= '0;
      xfer_strobe <= 1'b0;
    end else begin
      state       <= state_nx;
      xfer_strobe <= (state == LOAD);
      if (state == ARB) begin
        win_q    <= arb_idx;
        win_oh_q <= arb_grant;
      end
      if (state == LOAD) begin
        xfer_data  <= words[win_q];
        xfer_id    <= win_q;
        last_grant <= win_q;
      end
    end
  end

`ifdef CDC_SCHED_IDLE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state == ARB && !arb_any) begin
      idle_cnt <= sat_inc(idle_cnt);
    end
  end
`endif

endmodule
